// File: rtl/udp_status_responder.sv
// ---------------------------------------------------------------------------
// udp_status_responder
//
// Converts per-packet completion / error pulses from the UDP command writer
// into 9-byte ACK/NACK status replies streamed to the Ethernet core's
// udp0_sink port. Running good-packet and error counters are embedded in
// every reply so the host can pace uploads and detect loss.
//
// Reply frame: MAGIC, type, seq[15:8], seq[7:0], rx[15:8], rx[7:0],
//              err[15:8], err[7:0], chk (XOR of the first eight bytes)
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   pkt_done, pkt_error   one-cycle event pulses (error wins when both high)
//   pkt_seq               sequence number qualified by either pulse
//   udp0_sink_*           byte stream towards the core (valid/ready/last)
//   drop_count            saturating count of replies lost to a full slot
//   busy                  frame in flight or reply pending
// ---------------------------------------------------------------------------
module udp_status_responder #(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter int         ACK_EVERY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pkt_done,
    input  logic        pkt_error,
    input  logic [15:0] pkt_seq,
    output logic        udp0_sink_valid,
    output logic        udp0_sink_last,
    input  logic        udp0_sink_ready,
    output logic [7:0]  udp0_sink_data,
    output logic [15:0] drop_count,
    output logic        busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] ACK_DIV_LAST = 8'(ACK_EVERY - 1);
    localparam logic [7:0] TYPE_ACK     = 8'h01;
    localparam logic [7:0] TYPE_NACK    = 8'h02;

    state_t      state_q, state_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] err_q, err_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] drop_q, drop_d;

    // Depth-1 pending reply slot
    logic        pend_q, pend_d;
    logic [7:0]  pend_type_q, pend_type_d;
    logic [15:0] pend_seq_q, pend_seq_d;
    logic [15:0] pend_rx_q, pend_rx_d;
    logic [15:0] pend_err_q, pend_err_d;

    // Frame currently being transmitted
    logic [7:0]  fr_type_q, fr_type_d;
    logic [15:0] fr_seq_q, fr_seq_d;
    logic [15:0] fr_rx_q, fr_rx_d;
    logic [15:0] fr_err_q, fr_err_d;
    logic [3:0]  idx_q, idx_d;

    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [7:0]  data_q, data_d;

    logic        req;
    logic [7:0]  req_type;
    logic        handshake;
    logic        frame_done;
    logic        load;
    logic        slot_free;

    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  t,
        input logic [15:0] s,
        input logic [15:0] r,
        input logic [15:0] e
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = MAGIC;
            4'd1:    b = t;
            4'd2:    b = s[15:8];
            4'd3:    b = s[7:0];
            4'd4:    b = r[15:8];
            4'd5:    b = r[7:0];
            4'd6:    b = e[15:8];
            4'd7:    b = e[7:0];
            4'd8:    b = MAGIC ^ t ^ s[15:8] ^ s[7:0] ^ r[15:8] ^ r[7:0] ^ e[15:8] ^ e[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        rx_d        = rx_q;
        err_d       = err_q;
        div_d       = div_q;
        drop_d      = drop_q;
        pend_d      = pend_q;
        pend_type_d = pend_type_q;
        pend_seq_d  = pend_seq_q;
        pend_rx_d   = pend_rx_q;
        pend_err_d  = pend_err_q;
        fr_type_d   = fr_type_q;
        fr_seq_d    = fr_seq_q;
        fr_rx_d     = fr_rx_q;
        fr_err_d    = fr_err_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        last_d      = last_q;
        data_d      = data_q;
        req         = 1'b0;
        req_type    = 8'h00;

        // Event classification; an error pulse masks a simultaneous done
        if (pkt_error) begin
            err_d    = err_q + 16'd1;
            req      = 1'b1;
            req_type = TYPE_NACK;
        end else if (pkt_done) begin
            rx_d = rx_q + 16'd1;
            if (div_q == ACK_DIV_LAST) begin
                div_d    = 8'd0;
                req      = 1'b1;
                req_type = TYPE_ACK;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        handshake  = valid_q & udp0_sink_ready;
        frame_done = (state_q == SEND) & handshake & last_q;
        load       = pend_q & ((state_q == IDLE) | frame_done);
        // The slot counts as free in the cycle it drains into the frame
        slot_free  = ~pend_q | load;

        if ((state_q == SEND) && handshake && !last_q) begin
            idx_d  = idx_q + 4'd1;
            data_d = frame_byte(idx_q + 4'd1, fr_type_q, fr_seq_q, fr_rx_q, fr_err_q);
            last_d = (idx_q == 4'd7);
        end

        if (frame_done) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
        end

        // Loading overrides frame_done so back-to-back frames have no bubble
        if (load) begin
            state_d   = SEND;
            fr_type_d = pend_type_q;
            fr_seq_d  = pend_seq_q;
            fr_rx_d   = pend_rx_q;
            fr_err_d  = pend_err_q;
            idx_d     = 4'd0;
            valid_d   = 1'b1;
            last_d    = 1'b0;
            data_d    = MAGIC;
            pend_d    = 1'b0;
        end

        if (req) begin
            if (slot_free) begin
                pend_d      = 1'b1;
                pend_type_d = req_type;
                pend_seq_d  = pkt_seq;
                pend_rx_d   = rx_d;
                pend_err_d  = err_d;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_q        <= 16'd0;
            err_q       <= 16'd0;
            div_q       <= 8'd0;
            drop_q      <= 16'd0;
            pend_q      <= 1'b0;
            pend_type_q <= 8'd0;
            pend_seq_q  <= 16'd0;
            pend_rx_q   <= 16'd0;
            pend_err_q  <= 16'd0;
            fr_type_q   <= 8'd0;
            fr_seq_q    <= 16'd0;
            fr_rx_q     <= 16'd0;
            fr_err_q    <= 16'd0;
            idx_q       <= 4'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            div_q       <= div_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            pend_type_q <= pend_type_d;
            pend_seq_q  <= pend_seq_d;
            pend_rx_q   <= pend_rx_d;
            pend_err_q  <= pend_err_d;
            fr_type_q   <= fr_type_d;
            fr_seq_q    <= fr_seq_d;
            fr_rx_q     <= fr_rx_d;
            fr_err_q    <= fr_err_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            data_q      <= data_d;
        end
    end

    assign udp0_sink_valid = valid_q;
    assign udp0_sink_last  = last_q;
    assign udp0_sink_data  = data_q;
    assign drop_count      = drop_q;
    assign busy            = (state_q == SEND) | pend_q;

endmodule

// File: doc/udp_status_responder.md
Name: udp_status_responder

Overview:
- Downstream of the UDP command writer and upstream of the Ethernet core's udp0_sink port.
- Turns per-packet completion and error events from the command writer into short UDP status replies (ACK/NACK) back to the host.
- Keeps running good-packet and error counters and embeds them in each reply, so host software can pace frame uploads and detect loss.

Parameters:
- MAGIC, 8'hA5, first byte of every reply.
- ACK_EVERY, 1, send one ACK per ACK_EVERY good packets; legal range 1..255.

Ports:
- clock  input  1  system clock, same domain as the Ethernet core's sys_clock
- reset  input  1  synchronous, active-high
- pkt_done  input  1  one-cycle pulse: one command packet was consumed without error
- pkt_error  input  1  one-cycle pulse: one command packet was aborted or flagged in error
- pkt_seq  input  16  sequence number of the packet; valid in the cycle of pkt_done or pkt_error
- udp0_sink_valid  output  1  reply byte valid
- udp0_sink_last  output  1  final byte of reply
- udp0_sink_ready  input  1  core accepts byte
- udp0_sink_data  output  8  reply byte
- drop_count  output  16  replies discarded because the pending slot was full
- busy  output  1  high in SEND state or while the pending slot is occupied

Behaviour:
- Reset values: udp0_sink_valid=0, udp0_sink_last=0, udp0_sink_data=0, drop_count=0, busy=0. Internal rx_count, err_count, ack divider, pending flag and state (IDLE) are also cleared.
- Event classification:
  - pkt_error=1 is an error event, regardless of pkt_done.
  - pkt_done=1 with pkt_error=0 is a good event.
  - When both are high in the same cycle, only err_count increments.
- Counters: rx_count +1 per good event; err_count +1 per error event. Both are 16 bits and wrap 0xFFFF→0x0000.
- Ack divider:
  - Increments on each good event.
  - When it equals ACK_EVERY-1, the event requests an ACK (type 8'h01) and the divider clears.
  - Error events always request a NACK (type 8'h02) and leave the divider untouched.
- Pending slot (depth 1):
  - A request captures type, pkt_seq, and the post-increment rx_count and err_count.
  - If the slot is already full, the request is dropped. drop_count increments (saturates at 0xFFFF) and the counters still update.
  - A request arriving in the same cycle the slot drains is accepted.
- FSM IDLE→SEND: when the pending slot is full, at the clock edge.
  - The 9-byte frame is loaded and the slot freed.
  - udp0_sink_valid rises in that next cycle.
  - Latency: event in cycle N with FSM idle and slot empty gives first byte valid in cycle N+2.
- Frame bytes, in order:
  - MAGIC
  - type
  - seq[15:8], seq[7:0]
  - rx[15:8], rx[7:0]
  - err[15:8], err[7:0]
  - chk = XOR of bytes 0..7
- udp0_sink_last is high only with byte 8.
- Handshake:
  - A byte advances only on valid&ready.
  - While valid&!ready, data and last hold stable.
  - Valid never drops mid-frame.
- FSM SEND→IDLE: on valid&ready&last. If the slot is full at that edge, the FSM goes straight back to SEND with no bubble cycle.
- Reset mid-frame: the frame is abandoned, valid=0 next cycle, all counters and the pending slot are cleared.

Test Plan:
- Reset, then pkt_done with seq=0x1234, ready tied 1 → bytes A5 01 12 34 00 01 00 00 and chk=0x83 in cycles N+2..N+10; last on the 9th byte only.
- pkt_done and pkt_error together with seq=0x0007 → NACK A5 02 00 07 00 00 00 01 with chk=0xA1; rx_count stays 0.
- ACK_EVERY=4, six good pkt_done pulses spaced 20 cycles apart → exactly one reply, rx field 0x0004.
- ready held 0 for 5 cycles on byte 3 → data and last stable, valid high throughout; the frame then completes correctly.
- Three good events in back-to-back cycles with ready low → first is sent, second held pending, third dropped (drop_count=1). Second frame follows with no idle gap and rx=0x0002.
- rx_count preloaded to 0xFFFF via 65535 events, then one more pulse → reply rx field 0x0000 (wrap).
